// File: rtl/uart_rx.sv
// 8N1 serial receiver with a small byte FIFO, read over the memory-mapped bus.
// DATA (addr bit 2 = 0) pops the FIFO on read; STATUS (addr bit 2 = 1) holds count and sticky W1C error flags.
module uart_rx #(
    parameter int BAUD_DIVIDER   = 434,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
);
    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam logic [15:0] HALF_BIT  = 16'(BAUD_DIVIDER / 2);
    // The clearing cycle is counted, so each data/stop bit lasts exactly BAUD_DIVIDER cycles.
    localparam logic [15:0] LAST_TICK = 16'(BAUD_DIVIDER - 1);
    localparam logic [FIFO_ADDR_BITS:0] CNT_ONE  = (FIFO_ADDR_BITS+1)'(1);
    localparam logic [FIFO_ADDR_BITS:0] CNT_FULL = (FIFO_ADDR_BITS+1)'(DEPTH);
    localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE = FIFO_ADDR_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAITHIGH
    } state_t;

    logic       sync1_q, rxd_q, rxd_prev_q;
    state_t     state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shifter_q, shifter_d;
    logic       push, frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxd_q      <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            sync1_q    <= serialIn;
            rxd_q      <= sync1_q;
            rxd_prev_q <= rxd_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shifter_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shifter_q <= shifter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shifter_d = shifter_q;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (rxd_prev_q && !rxd_q) state_d = S_START;
            end
            S_START: begin
                if (timer_q == HALF_BIT) begin
                    timer_d = '0;
                    if (rxd_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (timer_q == LAST_TICK) begin
                    timer_d   = '0;
                    shifter_d = {rxd_q, shifter_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (timer_q == LAST_TICK) begin
                    timer_d = '0;
                    if (rxd_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = S_WAITHIGH;
                    end
                end
            end
            S_WAITHIGH: begin
                timer_d = '0;
                if (rxd_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [7:0]                fifo_mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_BITS:0]   count_q, count_d;
    logic                      overrun_q, overrun_d, ferr_q, ferr_d;
    logic                      rdy_q;
    logic                      handshake, sel_status, is_read, empty, full, pop, push_ok, w1c;

    assign handshake  = mem_valid & enable & rdy_q;
    assign sel_status = mem_addr[2];
    assign is_read    = (mem_wstrb == 4'b0000);
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_FULL);
    assign pop        = handshake & !sel_status & is_read & !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign push_ok    = push & (!full | pop);
    assign w1c        = handshake & sel_status & mem_wstrb[0];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) count_d = count_q + CNT_ONE;
        else if (pop && !push_ok) count_d = count_q - CNT_ONE;

        overrun_d = overrun_q;
        if (push && full && !pop) overrun_d = 1'b1;
        else if (w1c && mem_wdata[2]) overrun_d = 1'b0;

        ferr_d = ferr_q;
        if (frame_err) ferr_d = 1'b1;
        else if (w1c && mem_wdata[3]) ferr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= shifter_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
            rdy_q     <= mem_valid & enable & !rdy_q;
        end
    end

    logic [31:0] status_word, data_word;
    assign status_word = {24'b0, 4'(count_q), ferr_q, overrun_q, full, !empty};
    assign data_word   = empty ? 32'b0 : {24'b0, fifo_mem[rd_ptr_q]};
    assign mem_ready   = enable ? rdy_q : 1'b0;
    assign mem_rdata   = enable ? (sel_status ? status_word : data_word) : 32'b0;

    logic unused_bus;
    assign unused_bus = ^{mem_instr, mem_addr[31:3], mem_addr[1:0], mem_wdata[31:4], mem_wdata[1:0]};
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: bus accesses queue expected read data from a byte-level
// model of the receiver; a monitor compares whenever the DUT acknowledges.
module tb_uart_rx;
    localparam int B = 16;

    logic        clk = 1'b0;
    logic        reset, enable, mem_valid, mem_ready, mem_instr, serialIn;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata, mem_addr, mem_rdata;

    uart_rx #(.BAUD_DIVIDER(B), .FIFO_ADDR_BITS(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .serialIn(serialIn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] mq[$];
    logic       m_ov, m_fe;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] status_model();
        int n;
        n = mq.size();
        return {24'b0, 4'(n), m_fe, m_ov, n == 4, n != 0};
    endfunction

    // Must be called right after a falling clock edge; returns right after one.
    task automatic bus_access(input logic is_status, input logic [3:0] wstrb, input logic [31:0] wdata,
                              input logic chk, input logic [31:0] exp, input string name);
        sb_t e;
        int  n;
        e.chk = chk; e.exp = exp; e.name = name;
        sb_q.push_back(e);
        enable = 1'b1; mem_valid = 1'b1; mem_wstrb = wstrb; mem_wdata = wdata;
        mem_addr = is_status ? 32'h4 : 32'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 10);
        if (!mem_ready) begin
            checks++; errors++;
            $display("FAIL %s: mem_ready never rose, got 0 required 1", name);
            void'(sb_q.pop_back());
        end else begin
            @(negedge clk);
        end
        enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'b0; mem_wdata = 32'b0; mem_addr = 32'b0;
    endtask

    task automatic read_status(input string name);
        bus_access(1'b1, 4'b0, 32'b0, 1'b1, status_model(), name);
    endtask

    task automatic read_data(input string name);
        logic [31:0] exp;
        exp = 32'b0;
        if (mq.size() != 0) exp = {24'b0, mq.pop_front()};
        bus_access(1'b0, 4'b0, 32'b0, 1'b1, exp, name);
    endtask

    task automatic write_status(input logic [31:0] w);
        if (w[2]) m_ov = 1'b0;
        if (w[3]) m_fe = 1'b0;
        bus_access(1'b1, 4'b0001, w, 1'b0, 32'b0, "w1c");
    endtask

    task automatic write_data(input logic [31:0] w);
        bus_access(1'b0, 4'b1111, w, 1'b0, 32'b0, "data_write");
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        serialIn = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            repeat (B) @(negedge clk);
        end
        serialIn = stop;
        repeat (B) @(negedge clk);
        if (stop) begin
            if (mq.size() < 4) mq.push_back(b);
            else m_ov = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    initial begin : monitor
        logic prev_ready;
        sb_t  e;
        prev_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                checks++;
                if (prev_ready) begin
                    errors++;
                    $display("FAIL ready_pulse: mem_ready high 2 cycles, got 1 required 0");
                end
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: got mem_ready=1 with no access pending, required 0");
                end else begin
                    e = sb_q.pop_front();
                    $display("bus %s rdata=0x%08h", e.name, mem_rdata);
                    if (e.chk) check(e.name, mem_rdata, e.exp);
                end
            end
            prev_ready = mem_ready;
        end
    end

    initial begin : watchdog
        #(1000000);
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1; serialIn = 1'b1; enable = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_wstrb = 4'b0; mem_wdata = 32'b0; mem_addr = 32'b0;
        m_ov = 1'b0; m_fe = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1; mem_addr = 32'h4; #1;
        check("reset_status", mem_rdata, 32'h0);
        check("reset_ready", {31'b0, mem_ready}, 32'h0);
        mem_addr = 32'h0; #1;
        check("reset_data", mem_rdata, 32'h0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        read_status("status_after_reset");

        send_frame(8'h55, 1'b1);
        read_status("t55_status");
        read_data("t55_data");
        read_status("t55_status_empty");

        serialIn = 1'b0;
        repeat (4) @(negedge clk);
        serialIn = 1'b1;
        repeat (30) @(negedge clk);
        read_status("glitch_status");

        send_frame(8'hA5, 1'b0);
        repeat (40) @(negedge clk);
        read_status("framing_status");
        serialIn = 1'b1;
        repeat (2 * B) @(negedge clk);
        send_frame(8'h3C, 1'b1);
        read_status("framing_after_3c");
        write_status(32'h8);
        read_status("framing_cleared");
        read_data("framing_data_3c");

        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        read_status("overrun_status");
        for (int k = 0; k < 5; k++) read_data("overrun_data");
        write_status(32'h4);
        read_status("overrun_cleared");

        send_frame(8'h11, 1'b1); send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1); send_frame(8'h44, 1'b1);
        read_status("collision_full");
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (154) @(negedge clk);
                read_data("collision_pop");
            end
        join
        read_status("collision_status");
        for (int k = 0; k < 4; k++) read_data("collision_drain");
        read_status("collision_empty");

        send_frame(8'h5A, 1'b1);
        serialIn = 1'b0; repeat (B) @(negedge clk);
        serialIn = 1'b1; repeat (B) @(negedge clk);
        serialIn = 1'b0; repeat (B) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h4; #1;
        check("midreset_status", mem_rdata, 32'h0);
        check("midreset_ready", {31'b0, mem_ready}, 32'h0);
        mem_addr = 32'h0; #1;
        check("midreset_data", mem_rdata, 32'h0);
        enable = 1'b0; mem_valid = 1'b0;
        mq.delete(); m_ov = 1'b0; m_fe = 1'b0;
        @(negedge clk);
        serialIn = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h9A, 1'b1);
        read_status("postreset_status");

        mem_valid = 1'b1; enable = 1'b0; mem_addr = 32'h0;
        repeat (6) begin
            @(negedge clk);
            check("disabled_ready", {31'b0, mem_ready}, 32'h0);
            check("disabled_rdata", mem_rdata, 32'h0);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        read_status("disabled_no_pop");
        read_data("postreset_data_9a");

        for (int it = 0; it < 10; it++) begin
            int nb, nr;
            nb = $urandom_range(1, 5);
            for (int k = 0; k < nb; k++) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                send_frame(8'($urandom), 1'b1);
            end
            if ($urandom_range(0, 2) == 0) write_data($urandom);
            read_status("rand_status");
            nr = $urandom_range(0, 5);
            for (int k = 0; k < nr; k++) read_data("rand_data");
            if ($urandom_range(0, 1) == 1) write_status(32'hC);
            read_status("rand_status_after");
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
